branch_predictor_btb: RTL and testbench

//  Parametrised branch target buffer with 2-bit saturating direction counters.

---
 rtl/branch_predictor_btb.sv | 153 +++++++++++++++
 tb/tb_branch_predictor_btb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// ---------------------------------------------------------------------------
// branch_predictor_btb
//
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Fetch looks up its PC combinationally against the registered table and gets
// a taken/target prediction in the same cycle. Decode returns the resolved
// outcome together with the prediction that was made for that instruction.
// The block trains the table, flags mispredicts with the correct redirect PC,
// and keeps running counts of resolved branches and mispredicts.
//
// Ports
//   i_clock            single clock, all state changes on posedge
//   i_reset            synchronous, active-high; clears table and statistics
//   i_fetch_pc         PC of the instruction currently in fetch
//   o_pred_taken       1 = predict taken
//   o_pred_target      predicted next PC (fetch_pc+4 when not taken)
//   i_upd_valid        1 = a branch/jump resolved in decode this cycle
//   i_upd_pc           PC of the resolved instruction
//   i_upd_taken        actual direction
//   i_upd_target       actual target (meaningful when i_upd_taken=1)
//   i_upd_pred_taken   direction originally predicted for this instruction
//   i_upd_pred_target  target originally predicted for this instruction
//   o_mispredict       1 = fetch path is wrong; flush IF and redirect
//   o_redirect_pc      correct next PC, valid when o_mispredict=1
//   o_stat_branches    count of accepted updates (wraps)
//   o_stat_mispredicts count of mispredicts (wraps)
// ---------------------------------------------------------------------------
module branch_predictor_btb #(
    parameter int         INDEX_BITS = 4,
    parameter int         TAG_BITS   = 8,
    parameter logic [1:0] CTR_ALLOC  = 2'b10
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_fetch_pc,
    output logic        o_pred_taken,
    output logic [31:0] o_pred_target,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    input  logic        i_upd_pred_taken,
    input  logic [31:0] i_upd_pred_target,
    output logic        o_mispredict,
    output logic [31:0] o_redirect_pc,
    output logic [31:0] o_stat_branches,
    output logic [31:0] o_stat_mispredicts
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int IDX_LO  = 2;
    localparam int IDX_HI  = INDEX_BITS + 1;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    // Table storage: plain flops so every entry can be cleared in one cycle.
    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];

    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    // Lookup side
    logic [INDEX_BITS-1:0] w_fetch_idx;
    logic [TAG_BITS-1:0]   w_fetch_tag;
    logic                  w_fetch_hit;

    // Update side
    logic [INDEX_BITS-1:0] w_upd_idx;
    logic [TAG_BITS-1:0]   w_upd_tag;
    logic                  w_upd_hit;
    logic [1:0]            w_ctr_inc;
    logic [1:0]            w_ctr_dec;
    logic                  w_mispredict;

    assign w_fetch_idx = i_fetch_pc[IDX_HI:IDX_LO];
    assign w_fetch_tag = i_fetch_pc[TAG_HI:TAG_LO];
    assign w_upd_idx   = i_upd_pc[IDX_HI:IDX_LO];
    assign w_upd_tag   = i_upd_pc[TAG_HI:TAG_LO];

    // Prediction reads registered state only, so an update in flight is not
    // bypassed: a same-cycle lookup of the entry being written sees old data.
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_fetch_hit   = 1'b0;
        o_pred_taken  = 1'b0;
        o_pred_target = i_fetch_pc + 32'd4;
        w_fetch_hit   = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
        if (w_fetch_hit && r_ctr[w_fetch_idx][1]) begin
            o_pred_taken  = 1'b1;
            o_pred_target = r_target[w_fetch_idx];
        end
    end

    // Resolution side: mispredict on wrong direction, or on a taken branch
    // whose predicted target differs from the actual one.
    always_comb begin
        w_upd_hit    = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
        w_ctr_inc    = (r_ctr[w_upd_idx] == 2'b11) ? 2'b11 : r_ctr[w_upd_idx] + 2'd1;
        w_ctr_dec    = (r_ctr[w_upd_idx] == 2'b00) ? 2'b00 : r_ctr[w_upd_idx] - 2'd1;
        w_mispredict = i_upd_valid &&
                       ((i_upd_taken != i_upd_pred_taken) ||
                        (i_upd_taken && (i_upd_target != i_upd_pred_target)));
    end

    assign o_mispredict       = w_mispredict;
    assign o_redirect_pc      = i_upd_taken ? i_upd_target : i_upd_pc + 32'd4;
    assign o_stat_branches    = r_stat_branches;
    assign o_stat_mispredicts = r_stat_mispredicts;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            // NOTE: the whole table is reset here (it is flops, not RAM), which
            // is what makes a mid-training reset forget every learned branch.
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b00;
            end
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (i_upd_valid) begin
                r_stat_branches <= r_stat_branches + 32'd1;
                if (w_upd_hit) begin
                    if (i_upd_taken) begin
                        r_ctr[w_upd_idx]    <= w_ctr_inc;
                        r_target[w_upd_idx] <= i_upd_target;
                    end else begin
                        r_ctr[w_upd_idx]    <= w_ctr_dec;
                    end
                end else if (i_upd_taken) begin
                    // Direct-mapped: a taken miss evicts whatever aliases here.
                    r_valid[w_upd_idx]  <= 1'b1;
                    r_tag[w_upd_idx]    <= w_upd_tag;
                    r_target[w_upd_idx] <= i_upd_target;
                    r_ctr[w_upd_idx]    <= CTR_ALLOC;
                end
                // A not-taken miss allocates nothing.
            end
            if (w_mispredict) begin
                r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_btb
//
// Directed bench for branch_predictor_btb with default parameters
// (INDEX_BITS=4, TAG_BITS=8, CTR_ALLOC=2'b10). Inputs change 1 ns after a
// rising edge; outputs are sampled 1 ns later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_branch_predictor_btb;

    logic        i_clock;
    logic        i_reset;
    logic [31:0] i_fetch_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_upd_valid;
    logic [31:0] i_upd_pc;
    logic        i_upd_taken;
    logic [31:0] i_upd_target;
    logic        i_upd_pred_taken;
    logic [31:0] i_upd_pred_target;
    logic        o_mispredict;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_stat_branches;
    logic [31:0] o_stat_mispredicts;

    int checks   = 0;
    int failures = 0;

    branch_predictor_btb dut (
        .i_clock            (i_clock),
        .i_reset            (i_reset),
        .i_fetch_pc         (i_fetch_pc),
        .o_pred_taken       (o_pred_taken),
        .o_pred_target      (o_pred_target),
        .i_upd_valid        (i_upd_valid),
        .i_upd_pc           (i_upd_pc),
        .i_upd_taken        (i_upd_taken),
        .i_upd_target       (i_upd_target),
        .i_upd_pred_taken   (i_upd_pred_taken),
        .i_upd_pred_target  (i_upd_pred_target),
        .o_mispredict       (o_mispredict),
        .o_redirect_pc      (o_redirect_pc),
        .o_stat_branches    (o_stat_branches),
        .o_stat_mispredicts (o_stat_mispredicts)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Look up a PC and compare the prediction.
    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_taken, input logic [31:0] exp_target);
        i_fetch_pc = pc;
        #1;
        check({tag, "_taken"},  {31'd0, o_pred_taken}, {31'd0, exp_taken});
        check({tag, "_target"}, o_pred_target, exp_target);
    endtask

    // Present one resolved branch, check the combinational resolution
    // outputs, then clock it into the table.
    task automatic update(input string tag, input logic [31:0] pc, input logic taken,
                          input logic [31:0] target, input logic ptaken,
                          input logic [31:0] ptarget, input logic exp_mis,
                          input logic [31:0] exp_redirect);
        i_upd_valid       = 1'b1;
        i_upd_pc          = pc;
        i_upd_taken       = taken;
        i_upd_target      = target;
        i_upd_pred_taken  = ptaken;
        i_upd_pred_target = ptarget;
        #1;
        check({tag, "_mis"},      {31'd0, o_mispredict}, {31'd0, exp_mis});
        check({tag, "_redirect"}, o_redirect_pc, exp_redirect);
        tick();
        i_upd_valid = 1'b0;
    endtask

    task automatic stats(input string tag, input logic [31:0] exp_br, input logic [31:0] exp_mis);
        #1;
        check({tag, "_branches"},    o_stat_branches, exp_br);
        check({tag, "_mispredicts"}, o_stat_mispredicts, exp_mis);
    endtask

    initial begin
        i_reset           = 1'b1;
        i_fetch_pc        = 32'h0040_0010;
        i_upd_valid       = 1'b0;
        i_upd_pc          = '0;
        i_upd_taken       = 1'b0;
        i_upd_target      = '0;
        i_upd_pred_taken  = 1'b0;
        i_upd_pred_target = '0;
        tick();
        tick();
        i_reset = 1'b0;

        // 1: empty table after reset
        lookup("rst_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);
        stats("rst", 32'd0, 32'd0);

        // 2: first taken branch allocates; same-cycle lookup sees old contents
        i_fetch_pc = 32'h0040_0010;
        i_upd_valid = 1'b1; i_upd_pc = 32'h0040_0010; i_upd_taken = 1'b1;
        i_upd_target = 32'h0040_0100; i_upd_pred_taken = 1'b0;
        i_upd_pred_target = 32'h0040_0014;
        #1;
        check("nobypass_taken", {31'd0, o_pred_taken}, 32'd0);
        update("alloc", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014,
               1'b1, 32'h0040_0100);
        lookup("alloc_lookup", 32'h0040_0010, 1'b1, 32'h0040_0100);
        stats("alloc", 32'd1, 32'd1);

        // 3: three taken (ctr 2->3->3->3), then four not taken (3->2->1->0->0)
        for (int k = 0; k < 3; k++) begin
            update("train_t", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100,
                   1'b0, 32'h0040_0100);
            lookup("train_t_lookup", 32'h0040_0010, 1'b1, 32'h0040_0100);
        end
        update("nt1", 32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0014);
        lookup("nt1_lookup", 32'h0040_0010, 1'b1, 32'h0040_0100);
        update("nt2", 32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0014);
        lookup("nt2_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);
        update("nt3", 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0040_0014, 1'b0, 32'h0040_0014);
        lookup("nt3_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);
        update("nt4", 32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0040_0014, 1'b0, 32'h0040_0014);
        lookup("nt4_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);
        stats("train", 32'd8, 32'd3);

        // 5: not-taken miss allocates nothing; redirect wraps at the top of memory
        update("miss_nt", 32'h0040_0020, 1'b0, 32'h0, 1'b0, 32'h0040_0024, 1'b0, 32'h0040_0024);
        lookup("miss_nt_lookup", 32'h0040_0020, 1'b0, 32'h0040_0024);
        update("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_0000);
        lookup("wrap_lookup", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
        stats("miss", 32'd10, 32'd3);

        // upd_valid low: no mispredict even with disagreeing fields, no counting
        i_upd_valid = 1'b0; i_upd_taken = 1'b1; i_upd_pred_taken = 1'b0;
        #1;
        check("idle_mis", {31'd0, o_mispredict}, 32'd0);
        tick();
        stats("idle", 32'd10, 32'd3);

        // Counter at 0 on a valid entry: two taken updates climb 0->1->2
        update("retrain1", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014,
               1'b1, 32'h0040_0100);
        lookup("retrain1_lookup", 32'h0040_0010, 1'b0, 32'h0040_0014);
        update("retrain2", 32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0, 32'h0040_0014,
               1'b1, 32'h0040_0100);
        lookup("retrain2_lookup", 32'h0040_0010, 1'b1, 32'h0040_0100);

        // 4: alias at the same index evicts the first PC
        update("alias", 32'h0040_0410, 1'b1, 32'h0040_0800, 1'b0, 32'h0040_0414,
               1'b1, 32'h0040_0800);
        lookup("alias_new", 32'h0040_0410, 1'b1, 32'h0040_0800);
        lookup("alias_old", 32'h0040_0010, 1'b0, 32'h0040_0014);

        // Right direction, wrong target: mispredict, target retrained
        i_fetch_pc = 32'h0040_0410;
        update("tgt", 32'h0040_0410, 1'b1, 32'h0040_0900, 1'b1, 32'h0040_0800,
               1'b1, 32'h0040_0900);
        lookup("tgt_lookup", 32'h0040_0410, 1'b1, 32'h0040_0900);
        stats("alias", 32'd14, 32'd7);

        // 6: reset with a taken update presented: update ignored, all cleared
        i_reset = 1'b1;
        i_upd_valid = 1'b1; i_upd_pc = 32'h0040_0020; i_upd_taken = 1'b1;
        i_upd_target = 32'h0040_0200; i_upd_pred_taken = 1'b0;
        i_upd_pred_target = 32'h0040_0024;
        tick();
        i_reset = 1'b0;
        i_upd_valid = 1'b0;
        lookup("clr_alias", 32'h0040_0410, 1'b0, 32'h0040_0414);
        lookup("clr_ignored", 32'h0040_0020, 1'b0, 32'h0040_0024);
        stats("clr", 32'd0, 32'd0);

        // Table and stats resume after reset
        update("post", 32'h0040_0020, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0024,
               1'b1, 32'h0040_0200);
        lookup("post_lookup", 32'h0040_0020, 1'b1, 32'h0040_0200);
        stats("post", 32'd1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
